usw_bank_writer: RTL and testbench

- Write-side counterpart of the two-bank staged read path (s2 address decode, s3 bank select, s4 data mux).
- Accepts parity-protected write requests at s1 and buffers them in order in a small s2 queue.
- Steers each write to bank0 or bank1 by address bit MIDX, issuing a one-cycle registered write strobe at s3.
- Parity failures are dropped and logged in a sticky error-capture register, which counts as the write-side analogue of ICErrData.

---
 rtl/usw_pkg.sv | 29 ++
 rtl/usw_wq.sv | 62 ++++++
 rtl/usw_bank_writer.sv | 124 ++++++++++++
 tb/tb_usw_bank_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usw_pkg.sv
// Shared types and helpers for the two-bank write path.
// No logic of its own; widths here set the default request geometry.
// Bank address helper drops the bank-select bit and closes the gap.
package usw_pkg;

    localparam int MPND     = 5;
    localparam int MIDX_DEF = 0;
    localparam int USW_AW   = 8;
    localparam int USW_DW   = MPND + 1;

    // One queued write request.
    typedef struct packed {
        logic [USW_AW-1:0] adr;
        logic [USW_DW-1:0] dat;
    } usw_wreq_t;

    // Remove bit midx from the request address: bits below midx stay put,
    // bits above it shift down by one.
    function automatic logic [USW_AW-2:0] usw_bank_adr(input logic [USW_AW-1:0] adr,
                                                       input int              midx);
        logic [USW_AW-2:0] r;
        r = '0;
        for (int i = 0; i < USW_AW - 1; i++) begin
            r[i] = (i < midx) ? adr[i] : adr[i+1];
        end
        return r;
    endfunction

endpackage

// File: rtl/usw_wq.sv
// In-order DEPTH-entry synchronous queue holding accepted write requests.
// Latency: an entry pushed at edge E is visible at the head after E (no bypass).
// Backpressure: o_full from registered count only; push when full and pop when empty are ignored.
module usw_wq #(
    parameter int W     = 14,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_push_dat;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/usw_bank_writer.sv
// Parity-checked write steering into two banks by address bit MIDX, with sticky error capture.
// Latency: accept at edge E0, bank strobe high in the cycle after E0+1; one write per cycle at most.
// Backpressure: wr_rdy_s1 drops when the queue is full; a stalled head bank blocks all younger writes.
module usw_bank_writer
    import usw_pkg::*;
#(
    parameter int AW    = USW_AW,
    parameter int DW    = USW_DW,
    parameter int MIDX  = MIDX_DEF,
    parameter int DEPTH = 2
) (
    input  logic          piclk,
    input  logic          k_i_reset,
    input  logic          wr_vld_s1,
    output logic          wr_rdy_s1,
    input  logic [AW-1:0] wr_adr_s1,
    input  logic [DW-1:0] wr_dat_s1,
    input  logic          wr_par_s1,
    input  logic          bank0_rdy,
    input  logic          bank1_rdy,
    output logic          bank0_we_s3,
    output logic          bank1_we_s3,
    output logic [AW-2:0] bank_adr_s3,
    output logic [DW-1:0] bank_dat_s3,
    output logic          err_vld,
    output logic          err_ovf,
    output logic [AW-1:0] err_adr,
    input  logic          err_clr,
    output logic [15:0]   wr_cnt
);

    usw_wreq_t     w_in_req;
    usw_wreq_t     w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_acc;
    logic          w_par_ok;
    logic          w_push;
    logic          w_err;
    logic          w_hb;
    logic          w_pop;

    logic          r_we0;
    logic          r_we1;
    logic [AW-2:0] r_badr;
    logic [DW-1:0] r_bdat;
    logic          r_err_vld;
    logic          r_err_ovf;
    logic [AW-1:0] r_err_adr;
    logic [15:0]   r_wr_cnt;

    assign w_in_req  = {wr_adr_s1, wr_dat_s1};
    assign wr_rdy_s1 = ~w_full;
    assign w_acc     = wr_vld_s1 & wr_rdy_s1;
    assign w_par_ok  = ~(^{wr_dat_s1, wr_par_s1});
    assign w_push    = w_acc & w_par_ok;
    assign w_err     = w_acc & ~w_par_ok;
    assign w_hb      = w_head.adr[MIDX];
    assign w_pop     = ~w_empty & (w_hb ? bank1_rdy : bank0_rdy);

    usw_wq #(
        .W     ($bits(usw_wreq_t)),
        .DEPTH (DEPTH)
    ) u_wq (
        .clk        (piclk),
        .rst        (k_i_reset),
        .i_push     (w_push),
        .i_push_dat (w_in_req),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    // s3 issue stage: one-cycle strobe for the popped head; address/data hold between writes.
    always_ff @(posedge piclk or posedge k_i_reset) begin
        if (k_i_reset) begin
            r_we0    <= 1'b0;
            r_we1    <= 1'b0;
            r_badr   <= '0;
            r_bdat   <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_we0 <= w_pop & ~w_hb;
            r_we1 <= w_pop & w_hb;
            if (w_pop) begin
                r_badr   <= usw_bank_adr(w_head.adr, MIDX);
                r_bdat   <= w_head.dat;
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    // Sticky error capture; a new error in the same cycle as err_clr restarts the capture.
    always_ff @(posedge piclk or posedge k_i_reset) begin
        if (k_i_reset) begin
            r_err_vld <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_adr <= '0;
        end else if (w_err) begin
            if (!r_err_vld || err_clr) begin
                r_err_vld <= 1'b1;
                r_err_ovf <= 1'b0;
                r_err_adr <= wr_adr_s1;
            end else begin
                r_err_ovf <= 1'b1;
            end
        end else if (err_clr) begin
            r_err_vld <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_adr <= '0;
        end
    end

    assign bank0_we_s3 = r_we0;
    assign bank1_we_s3 = r_we1;
    assign bank_adr_s3 = r_badr;
    assign bank_dat_s3 = r_bdat;
    assign err_vld     = r_err_vld;
    assign err_ovf     = r_err_ovf;
    assign err_adr     = r_err_adr;
    assign wr_cnt      = r_wr_cnt;

endmodule

// File: tb/tb_usw_bank_writer.sv
// Directed bench for usw_bank_writer with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Every comparison is an immediate assertion that counts passes and totals.
module tb_usw_bank_writer;

    logic        piclk;
    logic        k_i_reset;
    logic        wr_vld_s1;
    logic        wr_rdy_s1;
    logic [7:0]  wr_adr_s1;
    logic [5:0]  wr_dat_s1;
    logic        wr_par_s1;
    logic        bank0_rdy;
    logic        bank1_rdy;
    logic        bank0_we_s3;
    logic        bank1_we_s3;
    logic [6:0]  bank_adr_s3;
    logic [5:0]  bank_dat_s3;
    logic        err_vld;
    logic        err_ovf;
    logic [7:0]  err_adr;
    logic        err_clr;
    logic [15:0] wr_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    usw_bank_writer dut (
        .piclk       (piclk),
        .k_i_reset   (k_i_reset),
        .wr_vld_s1   (wr_vld_s1),
        .wr_rdy_s1   (wr_rdy_s1),
        .wr_adr_s1   (wr_adr_s1),
        .wr_dat_s1   (wr_dat_s1),
        .wr_par_s1   (wr_par_s1),
        .bank0_rdy   (bank0_rdy),
        .bank1_rdy   (bank1_rdy),
        .bank0_we_s3 (bank0_we_s3),
        .bank1_we_s3 (bank1_we_s3),
        .bank_adr_s3 (bank_adr_s3),
        .bank_dat_s3 (bank_dat_s3),
        .err_vld     (err_vld),
        .err_ovf     (err_ovf),
        .err_adr     (err_adr),
        .err_clr     (err_clr),
        .wr_cnt      (wr_cnt)
    );

    initial piclk = 1'b0;
    always #5 piclk = ~piclk;

    task automatic tick();
        @(posedge piclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // bad=1 flips the parity bit so the request fails the even-parity check.
    task automatic drive(input logic v, input logic [7:0] a, input logic [5:0] d, input logic bad);
        wr_vld_s1 = v;
        wr_adr_s1 = a;
        wr_dat_s1 = d;
        wr_par_s1 = (^d) ^ bad;
    endtask

    task automatic chk_we(input string tag, input logic e0, input logic e1);
        chk({tag, "_we0"}, {31'd0, bank0_we_s3}, {31'd0, e0});
        chk({tag, "_we1"}, {31'd0, bank1_we_s3}, {31'd0, e1});
    endtask

    initial begin
        k_i_reset = 1'b1;
        err_clr   = 1'b0;
        bank0_rdy = 1'b0;
        bank1_rdy = 1'b0;
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        tick();
        tick();

        // Reset state.
        chk("rst_rdy", {31'd0, wr_rdy_s1}, 32'd1);
        chk_we("rst", 1'b0, 1'b0);
        chk("rst_badr", {25'd0, bank_adr_s3}, 32'h0);
        chk("rst_bdat", {26'd0, bank_dat_s3}, 32'h0);
        chk("rst_errv", {31'd0, err_vld}, 32'd0);
        chk("rst_erro", {31'd0, err_ovf}, 32'd0);
        chk("rst_erra", {24'd0, err_adr}, 32'h0);
        chk("rst_cnt", {16'd0, wr_cnt}, 32'd0);
        k_i_reset = 1'b0;

        // Single write: adr 05 -> bank1, bank address 02.
        bank0_rdy = 1'b1;
        bank1_rdy = 1'b1;
        drive(1'b1, 8'h05, 6'h2A, 1'b0);
        chk("s1_par", {31'd0, wr_par_s1}, 32'd1);
        tick();
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk_we("s1_c1", 1'b0, 1'b0);
        tick();
        chk_we("s1_c2", 1'b0, 1'b1);
        chk("s1_badr", {25'd0, bank_adr_s3}, 32'h02);
        chk("s1_bdat", {26'd0, bank_dat_s3}, 32'h2A);
        chk("s1_cnt", {16'd0, wr_cnt}, 32'd1);
        tick();
        chk_we("s1_c3", 1'b0, 1'b0);
        chk("s1_hold_adr", {25'd0, bank_adr_s3}, 32'h02);
        chk("s1_hold_dat", {26'd0, bank_dat_s3}, 32'h2A);

        // Back-to-back: adr 0..7, strobes alternate every cycle.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                drive(1'b1, 8'(i), 6'(i * 5 + 3), 1'b0);
                chk("b2b_rdy", {31'd0, wr_rdy_s1}, 32'd1);
            end else begin
                drive(1'b0, 8'h00, 6'h00, 1'b0);
            end
            tick();
            if (i >= 1) begin
                chk_we("b2b", ((i - 1) % 2) == 0, ((i - 1) % 2) == 1);
                chk("b2b_badr", {25'd0, bank_adr_s3}, 32'((i - 1) / 2));
                chk("b2b_bdat", {26'd0, bank_dat_s3}, 32'(((i - 1) * 5 + 3) % 64));
                chk("b2b_cnt", {16'd0, wr_cnt}, 32'(i + 1));
            end
        end
        tick();
        chk_we("b2b_end", 1'b0, 1'b0);

        // Head-of-line stall: bank1 head blocks a bank0 write behind it.
        bank1_rdy = 1'b0;
        drive(1'b1, 8'h01, 6'h15, 1'b0);
        tick();
        drive(1'b1, 8'h00, 6'h0C, 1'b0);
        tick();
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk("hol_rdy_full", {31'd0, wr_rdy_s1}, 32'd0);
        chk_we("hol_c0", 1'b0, 1'b0);
        tick();
        chk_we("hol_c1", 1'b0, 1'b0);
        chk("hol_rdy_full2", {31'd0, wr_rdy_s1}, 32'd0);
        bank1_rdy = 1'b1;
        tick();
        chk_we("hol_rel1", 1'b0, 1'b1);
        chk("hol_rel1_dat", {26'd0, bank_dat_s3}, 32'h15);
        chk("hol_rdy_back", {31'd0, wr_rdy_s1}, 32'd1);
        tick();
        chk_we("hol_rel0", 1'b1, 1'b0);
        chk("hol_rel0_dat", {26'd0, bank_dat_s3}, 32'h0C);
        chk("hol_rel0_adr", {25'd0, bank_adr_s3}, 32'h00);
        tick();
        chk_we("hol_end", 1'b0, 1'b0);
        chk("hol_cnt", {16'd0, wr_cnt}, 32'd11);

        // Parity errors: capture, overflow, clear-with-new-error, plain clear.
        drive(1'b1, 8'h10, 6'h01, 1'b1);
        tick();
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk("pe1_vld", {31'd0, err_vld}, 32'd1);
        chk("pe1_adr", {24'd0, err_adr}, 32'h10);
        chk("pe1_ovf", {31'd0, err_ovf}, 32'd0);
        drive(1'b1, 8'h20, 6'h03, 1'b1);
        tick();
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk_we("pe_nostrobe", 1'b0, 1'b0);
        chk("pe2_ovf", {31'd0, err_ovf}, 32'd1);
        chk("pe2_adr", {24'd0, err_adr}, 32'h10);
        tick();
        chk_we("pe_nostrobe2", 1'b0, 1'b0);
        chk("pe_cnt", {16'd0, wr_cnt}, 32'd11);
        err_clr = 1'b1;
        drive(1'b1, 8'h30, 6'h07, 1'b1);
        tick();
        err_clr = 1'b0;
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk("pe3_vld", {31'd0, err_vld}, 32'd1);
        chk("pe3_adr", {24'd0, err_adr}, 32'h30);
        chk("pe3_ovf", {31'd0, err_ovf}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("pec_vld", {31'd0, err_vld}, 32'd0);
        chk("pec_adr", {24'd0, err_adr}, 32'h00);

        // Reset mid-flight with a strobe in the air and an entry still queued.
        bank0_rdy = 1'b0;
        drive(1'b1, 8'h00, 6'h11, 1'b0);
        tick();
        drive(1'b1, 8'h02, 6'h22, 1'b0);
        tick();
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk("mr_full", {31'd0, wr_rdy_s1}, 32'd0);
        bank0_rdy = 1'b1;
        tick();
        bank0_rdy = 1'b0;
        chk_we("mr_inflight", 1'b1, 1'b0);
        chk("mr_cnt_pre", {16'd0, wr_cnt}, 32'd12);
        #2;
        k_i_reset = 1'b1;
        #1;
        chk_we("mr_async", 1'b0, 1'b0);
        chk("mr_rdy", {31'd0, wr_rdy_s1}, 32'd1);
        chk("mr_cnt", {16'd0, wr_cnt}, 32'd0);
        tick();
        k_i_reset = 1'b0;
        bank0_rdy = 1'b1;
        bank1_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_we("mr_post", 1'b0, 1'b0);
        end
        chk("mr_post_cnt", {16'd0, wr_cnt}, 32'd0);

        // wr_cnt wrap: 65534 writes at full rate, then three more.
        for (int i = 0; i < 65534; i++) begin
            drive(1'b1, 8'(i), 6'h00, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        tick();
        tick();
        chk("wrap_pre", {16'd0, wr_cnt}, 32'hFFFE);
        drive(1'b1, 8'h01, 6'h00, 1'b0);
        tick();
        drive(1'b1, 8'h02, 6'h00, 1'b0);
        tick();
        chk("wrap_ffff", {16'd0, wr_cnt}, 32'hFFFF);
        drive(1'b1, 8'h03, 6'h00, 1'b0);
        tick();
        drive(1'b0, 8'h00, 6'h00, 1'b0);
        chk("wrap_0000", {16'd0, wr_cnt}, 32'h0000);
        tick();
        chk("wrap_0001", {16'd0, wr_cnt}, 32'h0001);
        chk_we("wrap_last", 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
